// File: rtl/iterative_shifter.sv
// Multi-cycle shift unit: SLL/SRL/SRA/ROR. Shifts at most STEP positions per cycle
// through one STEP-wide barrel stage; signals completion with a one-cycle ready pulse.
module iterative_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_shift,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_resultRDY,
  output logic               busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int LVLS = $clog2(STEP) + 1;
  // One extra bit so STEP == WIDTH still fits in the compare.
  localparam int CW   = SHAMT_W + 1;

  logic [1:0]         state;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] rem;
  logic [1:0]         mode_q;

  logic [CW-1:0] rem_x, step_x, amt;
  logic          last;

  assign rem_x  = {1'b0, rem};
  assign step_x = CW'(STEP);
  assign amt    = (rem_x < step_x) ? rem_x : step_x;
  assign last   = (rem_x <= step_x);

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] x,
                                                input logic [1:0] m, input int s);
    logic [WIDTH-1:0] r;
    case (m)
      2'b00:   r = x << s;
      2'b01:   r = x >> s;
      2'b10:   r = $signed(x) >>> s;
      default: r = (x >> s) | (x << (WIDTH - s));
    endcase
    return r;
  endfunction

  // Log-shifter: stage i shifts by 2**i when amt[i] is set.
  logic [WIDTH-1:0] stg [LVLS+1];
  assign stg[0] = acc;

  for (genvar i = 0; i < LVLS; i++) begin : g_stage
    assign stg[i+1] = amt[i] ? shift_by(stg[i], mode_q, 1 << i) : stg[i];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      rem    <= '0;
      mode_q <= 2'b00;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (ctrl_shift) begin
            acc    <= operand;
            rem    <= shamt;
            mode_q <= mode;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          acc   <= stg[LVLS];
          rem   <= SHAMT_W'(rem_x - amt);
          state <= last ? DONE : SHIFT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data_result    = acc;
  assign data_resultRDY = (state == DONE);
  assign busy           = (state == SHIFT);

endmodule

// File: doc/iterative_shifter.md
Name: iterative_shifter

Overview:
- Parametrised multi-cycle shift unit for the ALU. Successor to the fixed single-stage barrel shift stages.
- Supports logical left, logical right, arithmetic right and rotate right over a configurable data width.
- Shifts up to STEP positions per clock and signals completion with a ready pulse, like the multi-cycle multiply/divide units.
- Trades latency for area: only one STEP-wide barrel stage is instantiated.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, shift-amount width; WIDTH must equal 2**SHAMT_W.
- STEP, 8, maximum positions shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ctrl_shift  input  1  start request; sampled on the rising edge.
- mode  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
- operand  input  WIDTH  value to shift; sampled with ctrl_shift.
- shamt  input  SHAMT_W  shift amount, 0..WIDTH-1; sampled with ctrl_shift.
- data_result  output  WIDTH  shifted result; held stable until the next accepted start.
- data_resultRDY  output  1  one-cycle pulse when data_result becomes valid.
- busy  output  1  high while a shift is in progress.

Behaviour:
- States: IDLE, SHIFT, DONE.
- Internal registers: accumulator acc[WIDTH], remaining rem[SHAMT_W], latched mode_q.
- Reset (asynchronous, any state, including mid-shift): state=IDLE, acc=0, rem=0, data_result=0, data_resultRDY=0, busy=0. The in-flight operation is abandoned and no ready pulse is produced.
- IDLE or DONE, with ctrl_shift=1 at an edge:
  - acc←operand, rem←shamt, mode_q←mode; next state SHIFT.
- IDLE or DONE, with ctrl_shift=0:
  - DONE→IDLE; IDLE stays IDLE.
- SHIFT, each edge:
  - amt=min(rem,STEP); acc←op(acc,amt); rem←rem−amt.
  - If rem≤STEP, next state DONE; otherwise stay in SHIFT.
  - ctrl_shift is ignored while in SHIFT; there is no queueing.
- Per-cycle operations by mode_q:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with acc[WIDTH-1]. The sign is preserved across iterations because each step re-reads the current MSB.
  - ROR: bits leaving at the LSB re-enter at the MSB.
- shamt=0 still takes exactly one SHIFT cycle with amt=0; the result equals operand.
- Latency:
  - With start sampled at edge E0, SHIFT occupies edges E1..Ek, where k=max(1, ceil(shamt/STEP)).
  - data_resultRDY rises at edge Ek and is high only during the DONE cycle.
  - data_result is driven combinationally from acc.
- busy = (state==SHIFT). It goes high at E0 and low at Ek.
- Back-to-back operation: a start accepted during the DONE cycle begins the next operation immediately, with no idle bubble. data_result then changes on the following edges.
- A change on operand, mode or shamt after E0 has no effect on the current operation.
- Only shift amounts up to STEP are synthesised per cycle: log2(STEP)+1 mux levels feeding one WIDTH-bit register.

Test Plan:
- SRA, operand 0x8000_0000, shamt 8, STEP 8 -> data_resultRDY 1 cycle after start; data_result 0xFF80_0000; busy high for exactly 1 cycle.
- SRL, operand 0xF000_000F, shamt 20, STEP 8 -> busy for 3 cycles; data_resultRDY at edge E3; data_result 0x0000_0F00; no ready pulse at E1 or E2.
- SLL, operand 0x0000_0001, shamt 31 -> k=4; data_result 0x8000_0000. ROR, operand 0x0000_00FF, shamt 4 -> k=1; data_result 0xF000_000F.
- shamt 0 in every mode, operand 0xA5A5_5A5A -> data_result 0xA5A5_5A5A; data_resultRDY 1 cycle after start.
- Start SRL, operand 0xFFFF_FFFF, shamt 31. Pulse ctrl_shift at E1 with different data -> ignored; data_result 0x0000_0001 at E4. A second start in the DONE cycle is accepted and its result follows k cycles later.
- Assert reset at E2 of a 4-cycle shift -> data_result=0, busy=0 and data_resultRDY=0 immediately (asynchronous). No ready pulse after reset is released; a new start then completes normally.
